// File: rtl/edged_pkg.sv
// rtl/edged_pkg.sv - lab-wide default width for the edged register
package edged_pkg;
    localparam int EDGED_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/edged.sv
// rtl/edged.sv - rising-edge D register with true and complemented outputs
module edged
    import edged_pkg::*;
#(
    parameter int               WIDTH       = EDGED_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

    // qn is not stored; it tracks q in the same timestep
    assign qn = ~q;

endmodule

// File: tb/tb_edged.sv
// tb/tb_edged.sv - scoreboard bench for edged across widths, reset values and irregular clocks
module tb_edged;

    logic       clk;
    logic       rst;
    logic       d1, d_rv, dr;
    logic [7:0] d8;
    logic       q1, qn1, q_rv, qn_rv, qr, qnr;
    logic [7:0] q8, qn8;

    logic [7:0] exp_q[$];
    logic [7:0] exp8_q[$];
    logic       expr_q[$];
    logic [7:0] e, e8;
    logic       model_q1, model_r, er;
    int         n_cmp, n_bad;

    edged dut1 (.clk(clk), .rst(rst), .d(d1), .q(q1), .qn(qn1));
    edged #(.WIDTH(1), .RESET_VALUE(1'b1)) dut_rv (.clk(clk), .rst(rst), .d(d_rv), .q(q_rv), .qn(qn_rv));
    edged #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .d(d8), .q(q8), .qn(qn8));
    edged dut_r (.clk(clk), .rst(rst), .d(dr), .q(qr), .qn(qnr));

    task automatic rise_sample();
        #5 clk = 1'b1;
        #1;
    endtask

    task automatic fall();
        #4 clk = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        d1   = 1'b1;
        d_rv = 1'b0;
        d8   = 8'hFF;
        exp_q.push_back(8'h00);
        exp8_q.push_back(8'h00);
        model_q1 = 1'b0;
        rise_sample();
        e  = exp_q.pop_front();
        e8 = exp8_q.pop_front();
        n_cmp++; if (q1 !== e[0])   begin n_bad++; $display("FAIL reset_q got %b want %b", q1, e[0]); end
        n_cmp++; if (qn1 !== ~e[0]) begin n_bad++; $display("FAIL reset_qn got %b want %b", qn1, ~e[0]); end
        n_cmp++; if (q_rv !== 1'b1) begin n_bad++; $display("FAIL reset_rv_q got %b want 1", q_rv); end
        n_cmp++; if (qn_rv !== 1'b0) begin n_bad++; $display("FAIL reset_rv_qn got %b want 0", qn_rv); end
        n_cmp++; if (q8 !== e8)     begin n_bad++; $display("FAIL reset_q8 got %h want %h", q8, e8); end
        n_cmp++; if (qn8 !== ~e8)   begin n_bad++; $display("FAIL reset_qn8 got %h want %h", qn8, ~e8); end
        fall();
    endtask

    task automatic test_capture();
        logic [4:0] pat;
        pat = 5'b01101;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d1 = pat[i];
            d8 = 8'($urandom_range(0, 255));
            exp_q.push_back({7'd0, d1});
            exp8_q.push_back(d8);
            model_q1 = d1;
            rise_sample();
            e  = exp_q.pop_front();
            e8 = exp8_q.pop_front();
            n_cmp++; if (q1 !== e[0])   begin n_bad++; $display("FAIL capture_q[%0d] got %b want %b", i, q1, e[0]); end
            n_cmp++; if (qn1 !== ~e[0]) begin n_bad++; $display("FAIL capture_qn[%0d] got %b want %b", i, qn1, ~e[0]); end
            n_cmp++; if (q8 !== e8)     begin n_bad++; $display("FAIL capture_q8[%0d] got %h want %h", i, q8, e8); end
            n_cmp++; if (qn8 !== ~e8)   begin n_bad++; $display("FAIL capture_qn8[%0d] got %h want %h", i, qn8, ~e8); end
            fall();
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            #40 d1 = ~d1;
            #1;
            n_cmp++; if (q1 !== model_q1)   begin n_bad++; $display("FAIL hold_q[%0d] got %b want %b", i, q1, model_q1); end
            n_cmp++; if (qn1 !== ~model_q1) begin n_bad++; $display("FAIL hold_qn[%0d] got %b want %b", i, qn1, ~model_q1); end
        end
        d1 = 1'b1;
        exp_q.push_back(8'h01);
        model_q1 = 1'b1;
        rise_sample();
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e[0]) begin n_bad++; $display("FAIL hold_capture got %b want %b", q1, e[0]); end
        d1 = 1'b0;
        #2 clk = 1'b0;
        #1;
        n_cmp++; if (q1 !== model_q1) begin n_bad++; $display("FAIL falling_edge_q got %b want %b", q1, model_q1); end
        #3;
    endtask

    task automatic test_sync_reset();
        rst = 1'b0;
        d1  = 1'b1;
        exp_q.push_back(8'h01);
        model_q1 = 1'b1;
        rise_sample();
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e[0]) begin n_bad++; $display("FAIL sr_setup got %b want %b", q1, e[0]); end
        fall();
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (q1 !== model_q1) begin n_bad++; $display("FAIL sr_midcycle got %b want %b", q1, model_q1); end
        exp_q.push_back(8'h00);
        model_q1 = 1'b0;
        rise_sample();
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e[0])   begin n_bad++; $display("FAIL sr_edge_q got %b want %b", q1, e[0]); end
        n_cmp++; if (qn1 !== ~e[0]) begin n_bad++; $display("FAIL sr_edge_qn got %b want %b", qn1, ~e[0]); end
        fall();
        rst = 1'b0;
        exp_q.push_back({7'd0, d1});
        model_q1 = d1;
        rise_sample();
        e = exp_q.pop_front();
        n_cmp++; if (q1 !== e[0]) begin n_bad++; $display("FAIL sr_release got %b want %b", q1, e[0]); end
        fall();
    endtask

    task automatic test_width();
        d8 = 8'hA5;
        rise_sample();
        n_cmp++; if (q8 !== 8'hA5)  begin n_bad++; $display("FAIL width_q8 got %h want a5", q8); end
        n_cmp++; if (qn8 !== 8'h5A) begin n_bad++; $display("FAIL width_qn8 got %h want 5a", qn8); end
        fall();
    endtask

    task automatic test_random_clock();
        logic old_d, old_clk, new_clk, pushed;
        model_r = 1'b0;
        for (int s = 0; s < 45; s++) begin
            old_d   = dr;
            old_clk = clk;
            new_clk = clk;
            pushed  = 1'b0;
            if (s % 5 == 0) begin
                if (s == 15)      new_clk = 1'b0;
                else if (s == 20) new_clk = 1'b1;
                else              new_clk = 1'($urandom_range(0, 1));
            end
            if (s % 4 == 0) dr <= ~dr;
            clk = new_clk;
            if (!old_clk && new_clk) begin
                expr_q.push_back(old_d);
                model_r = old_d;
                pushed  = 1'b1;
            end
            #1;
            if (pushed) begin
                er = expr_q.pop_front();
                n_cmp++; if (qr !== er) begin n_bad++; $display("FAIL rclk_edge[%0d] got %b want %b", s, qr, er); end
            end
            n_cmp++; if (qr !== model_r)   begin n_bad++; $display("FAIL rclk_q[%0d] got %b want %b", s, qr, model_r); end
            n_cmp++; if (qnr !== ~model_r) begin n_bad++; $display("FAIL rclk_qn[%0d] got %b want %b", s, qnr, ~model_r); end
            #9;
        end
        clk = 1'b0;
        #5;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        d1    = 1'b0;
        d_rv  = 1'b0;
        d8    = 8'h00;
        dr   <= 1'b0;
        #10;
        test_reset();
        test_capture();
        test_hold();
        test_sync_reset();
        test_width();
        test_random_clock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
